// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Ports: valid/ready in (number, signed_mode), valid/ready out (bcd, negative, sig_digits).
module bcd_seq_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            number,
  input  logic                        signed_mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [4*DIGITS-1:0]         bcd,
  output logic                        negative,
  output logic [$clog2(DIGITS+1)-1:0] sig_digits
);

  localparam int BW  = 4 * DIGITS;
  localparam int SRW = BW + WIDTH;
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int SW  = $clog2(DIGITS + 1);
  // ceil(WIDTH * log10(2)) in integer arithmetic
  localparam int MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000;

  if (WIDTH < 2) begin : g_bad_width
    $error("bcd_seq_converter: WIDTH must be >= 2");
  end
  if (DIGITS < MIN_DIGITS) begin : g_bad_digits
    $error("bcd_seq_converter: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [SRW-1:0]   sr;
  logic [SRW-1:0]   sr_adj;
  logic [SRW-1:0]   sr_sh;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic [WIDTH-1:0] mag;
  logic [SW-1:0]    sig_n;
  logic             take;
  logic             last;

  // Most negative input maps to 2^(WIDTH-1), still exact as unsigned.
  assign mag  = (signed_mode && number[WIDTH-1])
              ? (~number + WIDTH'(1)) : number;
  assign take = in_valid && in_ready;
  assign last = (state == SHIFT) && (cnt == CW'(1));

  always_comb begin
    sr_adj = sr;
    for (int k = 0; k < DIGITS; k++) begin
      if (sr[WIDTH+4*k +: 4] >= 4'd5)
        sr_adj[WIDTH+4*k +: 4] = sr[WIDTH+4*k +: 4] + 4'd3;
    end
  end

  assign sr_sh = sr_adj << 1;

  // Digit count of the field the final shift produces.
  always_comb begin
    sig_n = SW'(1);
    for (int k = 1; k < DIGITS; k++) begin
      if (sr_sh[WIDTH+4*k +: 4] != 4'd0)
        sig_n = SW'(k + 1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (take)      state_n = SHIFT;
      SHIFT:   if (last)      state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      bcd        <= '0;
      negative   <= 1'b0;
      sig_digits <= SW'(1);
      sr         <= '0;
      cnt        <= '0;
      neg_q      <= 1'b0;
    end else begin
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
      if (state == IDLE && take) begin
        sr    <= {{BW{1'b0}}, mag};
        cnt   <= CW'(WIDTH);
        // Negative inputs never have zero magnitude, so no -0.
        neg_q <= signed_mode && number[WIDTH-1];
      end else if (state == SHIFT) begin
        sr  <= sr_sh;
        cnt <= cnt - CW'(1);
        if (last) begin
          bcd        <= sr_sh[SRW-1 -: BW];
          negative   <= neg_q;
          sig_digits <= sig_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Bench for bcd_seq_converter: 8/3 and 16/5 instances,
// directed table, random vs decimal model, handshake corners.
module tb_bcd_seq_converter;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        iv_a, ir_a, sm_a, ov_a, or_a, neg_a;
  logic [7:0]  num_a;
  logic [11:0] bcd_a;
  logic [1:0]  sig_a;

  logic        iv_b, ir_b, sm_b, ov_b, or_b, neg_b;
  logic [15:0] num_b;
  logic [19:0] bcd_b;
  logic [2:0]  sig_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv_a), .in_ready(ir_a),
    .number(num_a), .signed_mode(sm_a),
    .out_valid(ov_a), .out_ready(or_a),
    .bcd(bcd_a), .negative(neg_a), .sig_digits(sig_a)
  );

  bcd_seq_converter #(.WIDTH(16), .DIGITS(5)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv_b), .in_ready(ir_b),
    .number(num_b), .signed_mode(sm_b),
    .out_valid(ov_b), .out_ready(or_b),
    .bcd(bcd_b), .negative(neg_b), .sig_digits(sig_b)
  );

  typedef struct {
    bit          big;
    logic [15:0] num;
    bit          sm;
    logic [19:0] bcd;
    bit          neg;
    int          sig;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  // Decimal reference: signed/unsigned value, then digits by /10.
  function automatic void model(input int w, input logic [15:0] num,
                                input bit sm, output logic [19:0] b,
                                output bit n, output int s);
    longint v, m, t;
    v = longint'(num) & ((longint'(1) << w) - 1);
    if (sm && v >= (longint'(1) << (w - 1)))
      v = v - (longint'(1) << w);
    n = (v < 0);
    m = n ? -v : v;
    b = '0;
    t = m;
    for (int d = 0; d < 5; d++) begin
      b[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    s = 1;
    t = m;
    while (t >= 10) begin
      t = t / 10;
      s++;
    end
  endfunction

  function automatic bit get_ir(input bit big);
    return big ? ir_b : ir_a;
  endfunction

  function automatic bit get_ov(input bit big);
    return big ? ov_b : ov_a;
  endfunction

  function automatic logic [19:0] get_bcd(input bit big);
    return big ? bcd_b : {8'h00, bcd_a};
  endfunction

  function automatic int get_sig(input bit big);
    return big ? int'(sig_b) : int'(sig_a);
  endfunction

  function automatic bit get_neg(input bit big);
    return big ? neg_b : neg_a;
  endfunction

  task automatic set_in(input bit big, input bit v,
                        input logic [15:0] num, input bit sm);
    if (big) begin
      iv_b = v; num_b = num; sm_b = sm;
    end else begin
      iv_a = v; num_a = num[7:0]; sm_a = sm;
    end
  endtask

  // Submit one number, return edges from accept until out_valid seen.
  task automatic convert(input bit big, input logic [15:0] num,
                         input bit sm, output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!get_ir(big) && g < 60) begin
      @(negedge clk);
      g++;
    end
    set_in(big, 1'b1, num, sm);
    @(negedge clk);
    set_in(big, 1'b0, num, sm);
    lat = 0;
    while (!get_ov(big) && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input string tag, input bit big,
                         input logic [15:0] num, input bit sm,
                         input logic [19:0] eb, input bit en,
                         input int es);
    int lat;
    int w;
    w = big ? 16 : 8;
    convert(big, num, sm, lat);
    // out_valid is registered after edge W, visible at edge W+1
    chk({tag, "_lat"}, lat, w);
    chk({tag, "_bcd"}, get_bcd(big), eb);
    chk({tag, "_neg"}, get_neg(big), en);
    chk({tag, "_sig"}, get_sig(big), es);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] eb;
    bit          en;
    int          es;
    logic [15:0] rn;
    bit          rs;
    int          lat;

    reset_n = 1'b0;
    set_in(0, 0, 0, 0);
    set_in(1, 0, 0, 0);
    or_a = 1'b1;
    or_b = 1'b1;

    vecs[0] = '{0, 16'h00FF, 0, 20'h00255, 0, 3};
    vecs[1] = '{0, 16'h0000, 0, 20'h00000, 0, 1};
    vecs[2] = '{0, 16'h0080, 1, 20'h00128, 1, 3};
    vecs[3] = '{0, 16'h00FF, 1, 20'h00001, 1, 1};
    vecs[4] = '{0, 16'h007F, 1, 20'h00127, 0, 3};
    vecs[5] = '{0, 16'h0000, 1, 20'h00000, 0, 1};
    vecs[6] = '{1, 16'hFFFF, 0, 20'h65535, 0, 5};
    vecs[7] = '{1, 16'h8000, 1, 20'h32768, 1, 5};
    vecs[8] = '{1, 16'hFFFF, 1, 20'h00001, 1, 1};
    vecs[9] = '{1, 16'h03E8, 0, 20'h01000, 0, 4};

    repeat (3) @(negedge clk);
    chk("rst_ready_a", ir_a, 1);
    chk("rst_valid_a", ov_a, 0);
    chk("rst_bcd_a", bcd_a, 0);
    chk("rst_neg_a", neg_a, 0);
    chk("rst_sig_a", sig_a, 1);
    chk("rst_ready_b", ir_b, 1);
    chk("rst_sig_b", sig_b, 1);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].big, vecs[i].num,
              vecs[i].sm, vecs[i].bcd, vecs[i].neg, vecs[i].sig);

    for (int i = 0; i < 40; i++) begin
      rn = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      model((i % 2) ? 16 : 8, rn, rs, eb, en, es);
      run_vec($sformatf("rnd%0d", i), 1'(i % 2), rn, rs, eb, en, es);
    end

    // Backpressure: hold 20 cycles, stray in_valid must be ignored.
    or_a = 1'b0;
    convert(0, 16'd200, 0, lat);
    chk("bp_lat", lat, 8);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5)  set_in(0, 1, 16'd7, 0);
      if (i == 10) set_in(0, 0, 16'd0, 0);
      chk($sformatf("bp_hold%0d", i),
          {ov_a, ir_a, neg_a, sig_a, bcd_a},
          {1'b1, 1'b0, 1'b0, 2'd3, 12'h200});
    end
    or_a = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", ov_a, 0);
    chk("bp_release_ready", ir_a, 1);
    chk("bp_release_hold", bcd_a, 12'h200);

    // Back-to-back with in_valid held high: 9, 10, 99.
    begin
      logic [15:0] vals[3];
      int idx, got, last, cyc;
      vals[0] = 16'd9;
      vals[1] = 16'd10;
      vals[2] = 16'd99;
      idx = 0; got = 0; last = 0; cyc = 0;
      while (got < 3 && cyc < 100) begin
        @(negedge clk);
        cyc++;
        if (ov_a) begin
          model(8, vals[got], 0, eb, en, es);
          chk($sformatf("b2b_bcd%0d", got), bcd_a, eb[11:0]);
          chk($sformatf("b2b_sig%0d", got), sig_a, es);
          if (got > 0)
            chk($sformatf("b2b_gap%0d", got), cyc - last, 10);
          last = cyc;
          got++;
        end
        if (ir_a) begin
          if (idx < 3) begin
            set_in(0, 1, vals[idx], 0);
            idx++;
          end else begin
            set_in(0, 0, 16'd0, 0);
          end
        end else if (idx < 3 && idx > 0) begin
          iv_a = 1'b1;
        end
      end
      set_in(0, 0, 16'd0, 0);
      chk("b2b_count", got, 3);
    end

    // Reset pulsed mid-SHIFT.
    begin
      int spur;
      @(negedge clk);
      set_in(0, 1, 16'd200, 0);
      @(negedge clk);
      set_in(0, 0, 16'd0, 0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_ready", ir_a, 1);
      chk("arst_valid", ov_a, 0);
      chk("arst_bcd", bcd_a, 0);
      chk("arst_neg", neg_a, 0);
      chk("arst_sig", sig_a, 1);
      @(negedge clk);
      reset_n = 1'b1;
      spur = 0;
      repeat (15) begin
        @(negedge clk);
        if (ov_a) spur++;
      end
      chk("arst_no_valid", spur, 0);
    end
    run_vec("post_rst", 0, 16'd42, 0, 20'h00042, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
